// File: rtl/fu_mul_pipe_pkg.sv
// Shared definitions for the pipelined multiplier: operation encodings
// and small decode helpers that select the extension of each operand.
package fu_mul_pipe_pkg;

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULH   = 2'b01,
        OP_MULHSU = 2'b10,
        OP_MULHU  = 2'b11
    } mul_op_e;

    // Operand A is sign-extended for MULH and MULHSU.
    function automatic logic op_a_signed(input logic [1:0] op);
        logic r;
        case (op)
            OP_MULH:   r = 1'b1;
            OP_MULHSU: r = 1'b1;
            default:   r = 1'b0;
        endcase
        return r;
    endfunction

    // Operand B is sign-extended only for MULH.
    function automatic logic op_b_signed(input logic [1:0] op);
        logic r;
        case (op)
            OP_MULH: r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mul_pipe_reg.sv
// One pipeline stage register: valid, op, tag and product payload.
// Bubbles carry an all-zero payload so a drained output reads zero.
module mul_pipe_reg #(
    parameter int DW   = 64,
    parameter int TAGW = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr_i,
    input  logic            en_i,
    input  logic            valid_i,
    input  logic [1:0]      op_i,
    input  logic [TAGW-1:0] tag_i,
    input  logic [DW-1:0]   data_i,
    output logic            valid_o,
    output logic [1:0]      op_o,
    output logic [TAGW-1:0] tag_o,
    output logic [DW-1:0]   data_o
);

    logic            valid_q, valid_d;
    logic [1:0]      op_q, op_d;
    logic [TAGW-1:0] tag_q, tag_d;
    logic [DW-1:0]   data_q, data_d;

    // Next state: flush clears, enable loads (zeroing bubbles), otherwise hold.
    always_comb begin
        valid_d = valid_q;
        op_d    = op_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (clr_i) begin
            valid_d = 1'b0;
            op_d    = 2'b00;
            tag_d   = {TAGW{1'b0}};
            data_d  = {DW{1'b0}};
        end else if (en_i) begin
            if (valid_i) begin
                valid_d = 1'b1;
                op_d    = op_i;
                tag_d   = tag_i;
                data_d  = data_i;
            end else begin
                valid_d = 1'b0;
                op_d    = 2'b00;
                tag_d   = {TAGW{1'b0}};
                data_d  = {DW{1'b0}};
            end
        end else begin
            valid_d = valid_q;
            op_d    = op_q;
            tag_d   = tag_q;
            data_d  = data_q;
        end
    end

    // Stage state register with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            op_q    <= 2'b00;
            tag_q   <= {TAGW{1'b0}};
            data_q  <= {DW{1'b0}};
        end else begin
            valid_q <= valid_d;
            op_q    <= op_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign op_o    = op_q;
    assign tag_o   = tag_q;
    assign data_o  = data_q;

endmodule

// File: rtl/fu_mul_pipe.sv
// Fixed-latency pipelined multiplier functional unit. The full product is
// formed before stage 1 and carried unchanged; the output stage selects the
// low or high half. A full output stage without grant freezes every stage.
module fu_mul_pipe
    import fu_mul_pipe_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int LAT  = 7,
    parameter int TAGW = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            EN,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic [TAGW-1:0] tag_in,
    input  logic            flush,
    input  logic            grant,
    output logic            ready,
    output logic            finish,
    output logic [XLEN-1:0] res,
    output logic [TAGW-1:0] tag_out
);

    // Index 0 is the stage-1 input; index LAT is the output stage.
    logic                vld_s  [0:LAT];
    logic [1:0]          op_s   [0:LAT];
    logic [TAGW-1:0]     tag_s  [0:LAT];
    logic [2*XLEN-1:0]   prod_s [0:LAT];

    logic                stall_s;
    logic                adv_s;
    logic                accept_s;
    logic [2*XLEN-1:0]   a_ext_s;
    logic [2*XLEN-1:0]   b_ext_s;

    assign stall_s  = vld_s[LAT] & ~grant;
    assign adv_s    = ~stall_s;
    assign ready    = ~vld_s[LAT] | grant;
    assign accept_s = EN & ready & ~flush;

    // Extend operands per mode; the low 2*XLEN bits of the wide product are
    // exact for every signedness combination.
    always_comb begin
        a_ext_s = {{XLEN{A[XLEN-1] & op_a_signed(op)}}, A};
        b_ext_s = {{XLEN{B[XLEN-1] & op_b_signed(op)}}, B};
    end

    assign vld_s[0]  = accept_s;
    assign op_s[0]   = op;
    assign tag_s[0]  = tag_in;
    assign prod_s[0] = a_ext_s * b_ext_s;

    for (genvar g = 1; g <= LAT; g++) begin : g_stage
        mul_pipe_reg #(
            .DW   (2 * XLEN),
            .TAGW (TAGW)
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .clr_i   (flush),
            .en_i    (adv_s),
            .valid_i (vld_s[g-1]),
            .op_i    (op_s[g-1]),
            .tag_i   (tag_s[g-1]),
            .data_i  (prod_s[g-1]),
            .valid_o (vld_s[g]),
            .op_o    (op_s[g]),
            .tag_o   (tag_s[g]),
            .data_o  (prod_s[g])
        );
    end

    // Pick the product half requested by the finished operation.
    always_comb begin
        res = prod_s[LAT][XLEN-1:0];
        case (op_s[LAT])
            OP_MUL:    res = prod_s[LAT][XLEN-1:0];
            OP_MULH:   res = prod_s[LAT][2*XLEN-1:XLEN];
            OP_MULHSU: res = prod_s[LAT][2*XLEN-1:XLEN];
            OP_MULHU:  res = prod_s[LAT][2*XLEN-1:XLEN];
            default:   res = prod_s[LAT][XLEN-1:0];
        endcase
    end

    assign finish  = vld_s[LAT];
    assign tag_out = tag_s[LAT];

endmodule

// File: tb/tb_fu_mul_pipe.sv
// Directed self-checking bench for fu_mul_pipe.
module tb_fu_mul_pipe;

    localparam int XLEN = 32;
    localparam int LAT  = 7;
    localparam int TAGW = 4;

    logic            clk;
    logic            rst_n;
    logic            EN;
    logic [1:0]      op;
    logic [XLEN-1:0] A;
    logic [XLEN-1:0] B;
    logic [TAGW-1:0] tag_in;
    logic            flush;
    logic            grant;
    logic            ready;
    logic            finish;
    logic [XLEN-1:0] res;
    logic [TAGW-1:0] tag_out;

    int n_cmp;
    int n_fail;

    logic [1:0]      t_op  [8];
    logic [XLEN-1:0] t_a   [8];
    logic [XLEN-1:0] t_b   [8];
    logic [TAGW-1:0] t_tag [8];
    logic [XLEN-1:0] t_res [8];

    fu_mul_pipe #(.XLEN(XLEN), .LAT(LAT), .TAGW(TAGW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .EN      (EN),
        .op      (op),
        .A       (A),
        .B       (B),
        .tag_in  (tag_in),
        .flush   (flush),
        .grant   (grant),
        .ready   (ready),
        .finish  (finish),
        .res     (res),
        .tag_out (tag_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue n table entries back-to-back with grant held, check each cycle.
    task automatic run_stream(input int n, input string name);
        int k;
        grant = 1'b1;
        for (int cyc = 0; cyc < n + LAT + 1; cyc++) begin
            if (cyc < n) begin
                EN = 1'b1; op = t_op[cyc]; A = t_a[cyc]; B = t_b[cyc]; tag_in = t_tag[cyc];
            end else begin
                EN = 1'b0;
            end
            step();
            k = cyc + 1 - LAT;
            if (k >= 0 && k < n) begin
                n_cmp++; if (finish !== 1'b1) begin n_fail++; $display("FAIL %s finish[%0d] got %0b want 1", name, k, finish); end
                n_cmp++; if (res !== t_res[k]) begin n_fail++; $display("FAIL %s res[%0d] got %h want %h", name, k, res, t_res[k]); end
                n_cmp++; if (tag_out !== t_tag[k]) begin n_fail++; $display("FAIL %s tag[%0d] got %0d want %0d", name, k, tag_out, t_tag[k]); end
            end else begin
                n_cmp++; if (finish !== 1'b0) begin n_fail++; $display("FAIL %s idle_finish cyc %0d got %0b want 0", name, cyc, finish); end
                n_cmp++; if (res !== 32'h0) begin n_fail++; $display("FAIL %s idle_res cyc %0d got %h want 0", name, cyc, res); end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; EN = 1'b0; op = 2'b00; A = 32'h0; B = 32'h0;
        tag_in = 4'h0; flush = 1'b0; grant = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (finish !== 1'b0) begin n_fail++; $display("FAIL reset_finish got %0b want 0", finish); end
        n_cmp++; if (res !== 32'h0) begin n_fail++; $display("FAIL reset_res got %h want 0", res); end
        n_cmp++; if (tag_out !== 4'h0) begin n_fail++; $display("FAIL reset_tag got %0d want 0", tag_out); end
        n_cmp++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %0b want 1", ready); end
        rst_n = 1'b1;
    endtask

    task automatic test_mul_basic();
        EN = 1'b1; op = 2'b00; A = 32'd7; B = 32'd6; tag_in = 4'd3; grant = 1'b1;
        n_cmp++; if (ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready got %0b want 1", ready); end
        step();
        EN = 1'b0;
        for (int i = 1; i < LAT; i++) begin
            n_cmp++; if (finish !== 1'b0) begin n_fail++; $display("FAIL basic_early cyc %0d got %0b want 0", i, finish); end
            step();
        end
        n_cmp++; if (finish !== 1'b1) begin n_fail++; $display("FAIL basic_finish got %0b want 1", finish); end
        n_cmp++; if (res !== 32'd42) begin n_fail++; $display("FAIL basic_res got %0d want 42", res); end
        n_cmp++; if (tag_out !== 4'd3) begin n_fail++; $display("FAIL basic_tag got %0d want 3", tag_out); end
        step();
        n_cmp++; if (finish !== 1'b0) begin n_fail++; $display("FAIL basic_single_pulse got %0b want 0", finish); end
        n_cmp++; if (res !== 32'h0) begin n_fail++; $display("FAIL basic_res_zero got %h want 0", res); end
    endtask

    task automatic test_modes();
        t_op[0] = 2'b01; t_a[0] = 32'hFFFFFFFF; t_b[0] = 32'hFFFFFFFF; t_tag[0] = 4'd8;  t_res[0] = 32'h00000000;
        t_op[1] = 2'b11; t_a[1] = 32'hFFFFFFFF; t_b[1] = 32'hFFFFFFFF; t_tag[1] = 4'd9;  t_res[1] = 32'hFFFFFFFE;
        t_op[2] = 2'b10; t_a[2] = 32'hFFFFFFFF; t_b[2] = 32'h00000002; t_tag[2] = 4'd10; t_res[2] = 32'hFFFFFFFF;
        t_op[3] = 2'b00; t_a[3] = 32'hFFFFFFFF; t_b[3] = 32'hFFFFFFFF; t_tag[3] = 4'd11; t_res[3] = 32'h00000001;
        t_op[4] = 2'b10; t_a[4] = 32'h00000003; t_b[4] = 32'h80000000; t_tag[4] = 4'd12; t_res[4] = 32'h00000001;
        run_stream(5, "modes");
    endtask

    task automatic test_back_to_back();
        t_op[0] = 2'b00; t_a[0] = 32'd3;  t_b[0] = 32'd11; t_tag[0] = 4'd1; t_res[0] = 32'd33;
        t_op[1] = 2'b00; t_a[1] = 32'd6;  t_b[1] = 32'd12; t_tag[1] = 4'd2; t_res[1] = 32'd72;
        t_op[2] = 2'b00; t_a[2] = 32'd9;  t_b[2] = 32'd13; t_tag[2] = 4'd3; t_res[2] = 32'd117;
        t_op[3] = 2'b00; t_a[3] = 32'd12; t_b[3] = 32'd14; t_tag[3] = 4'd4; t_res[3] = 32'd168;
        t_op[4] = 2'b00; t_a[4] = 32'd15; t_b[4] = 32'd15; t_tag[4] = 4'd5; t_res[4] = 32'd225;
        t_op[5] = 2'b00; t_a[5] = 32'd18; t_b[5] = 32'd16; t_tag[5] = 4'd6; t_res[5] = 32'd288;
        t_op[6] = 2'b00; t_a[6] = 32'd21; t_b[6] = 32'd17; t_tag[6] = 4'd7; t_res[6] = 32'd357;
        run_stream(7, "b2b");
    endtask

    task automatic test_stall();
        logic [XLEN-1:0] exp_res;
        grant = 1'b0;
        for (int cyc = 0; cyc < LAT; cyc++) begin
            if (cyc < 4) begin
                EN = 1'b1; op = 2'b00; A = 32'(cyc + 1); B = 32'd3; tag_in = 4'(cyc + 1);
            end else begin
                EN = 1'b0;
            end
            step();
        end
        for (int i = 0; i < 6; i++) begin
            n_cmp++; if (finish !== 1'b1) begin n_fail++; $display("FAIL stall_finish c%0d got %0b want 1", i, finish); end
            n_cmp++; if (tag_out !== 4'd1) begin n_fail++; $display("FAIL stall_tag c%0d got %0d want 1", i, tag_out); end
            n_cmp++; if (res !== 32'd3) begin n_fail++; $display("FAIL stall_res c%0d got %0d want 3", i, res); end
            n_cmp++; if (ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready c%0d got %0b want 0", i, ready); end
            if (i < 5) step();
        end
        grant = 1'b1;
        #1;
        n_cmp++; if (ready !== 1'b1) begin n_fail++; $display("FAIL stall_ready_grant got %0b want 1", ready); end
        for (int j = 1; j < 4; j++) begin
            step();
            exp_res = 32'(3 * (j + 1));
            n_cmp++; if (finish !== 1'b1) begin n_fail++; $display("FAIL drain_finish %0d got %0b want 1", j, finish); end
            n_cmp++; if (tag_out !== 4'(j + 1)) begin n_fail++; $display("FAIL drain_tag %0d got %0d want %0d", j, tag_out, j + 1); end
            n_cmp++; if (res !== exp_res) begin n_fail++; $display("FAIL drain_res %0d got %0d want %0d", j, res, exp_res); end
        end
        for (int j = 0; j < 2; j++) begin
            step();
            n_cmp++; if (finish !== 1'b0) begin n_fail++; $display("FAIL drain_empty %0d got %0b want 0", j, finish); end
        end
    endtask

    task automatic test_flush();
        grant = 1'b1;
        EN = 1'b1; op = 2'b00; A = 32'd2; B = 32'd2; tag_in = 4'd1;
        step();
        tag_in = 4'd2;
        step();
        tag_in = 4'd3; flush = 1'b1;
        #1;
        n_cmp++; if (ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready got %0b want 1", ready); end
        step();
        flush = 1'b0; EN = 1'b0;
        for (int i = 0; i < LAT + 2; i++) begin
            n_cmp++; if (finish !== 1'b0) begin n_fail++; $display("FAIL flush_finish c%0d got %0b want 0", i, finish); end
            step();
        end
        t_op[0] = 2'b00; t_a[0] = 32'd100; t_b[0] = 32'd5; t_tag[0] = 4'd5; t_res[0] = 32'd500;
        run_stream(1, "post_flush");
    endtask

    task automatic test_reset_mid();
        grant = 1'b0;
        for (int cyc = 0; cyc < LAT; cyc++) begin
            if (cyc < 2) begin
                EN = 1'b1; op = 2'b00; A = 32'(9 - 7 * cyc); B = 32'(9 - 7 * cyc); tag_in = 4'(6 + cyc);
            end else begin
                EN = 1'b0;
            end
            step();
        end
        n_cmp++; if (finish !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre_finish got %0b want 1", finish); end
        n_cmp++; if (res !== 32'd81) begin n_fail++; $display("FAIL rstmid_pre_res got %0d want 81", res); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (finish !== 1'b0) begin n_fail++; $display("FAIL rstmid_finish got %0b want 0", finish); end
        n_cmp++; if (res !== 32'h0) begin n_fail++; $display("FAIL rstmid_res got %h want 0", res); end
        n_cmp++; if (tag_out !== 4'h0) begin n_fail++; $display("FAIL rstmid_tag got %0d want 0", tag_out); end
        n_cmp++; if (ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready got %0b want 1", ready); end
        #3 rst_n = 1'b1;
        grant = 1'b1;
        for (int i = 0; i < LAT + 2; i++) begin
            step();
            n_cmp++; if (finish !== 1'b0) begin n_fail++; $display("FAIL rstmid_ghost c%0d got %0b want 0", i, finish); end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_mul_basic();
        test_modes();
        test_back_to_back();
        test_stall();
        test_flush();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fu_mul_pipe.md
FU_MUL_PIPE -- requirements
Module: fu_mul_pipe

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning operand and result width.
REQ-002 The block SHALL have parameter LAT, default 7, meaning issue-to-finish latency in cycles (legal range 2..16).
REQ-003 The block SHALL have parameter TAGW, default 4, meaning reservation-station tag width.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 EN  in  1  issue request; an operation is accepted when EN and ready are both 1.
REQ-007 op  in  2  mode: 00 MUL (low), 01 MULH (s×s high), 10 MULHSU (s×u high), 11 MULHU (u×u high).
REQ-008 A, B  in  XLEN each  operands; A is the signed operand for MULHSU.
REQ-009 tag_in  in  TAGW  tag carried with the operation.
REQ-010 flush  in  1  discard all in-flight operations.
REQ-011 grant  in  1  result-bus grant; consumes the finished result.
REQ-012 ready  out  1  pipeline can accept an issue this cycle.
REQ-013 finish  out  1  res/tag_out hold a valid result.
REQ-014 res  out  XLEN  selected product bits.
REQ-015 tag_out  out  TAGW  tag of the finished result.

Function
REQ-016 Pipeline SHALL have LAT stages, each holding valid, op, tag and partial/final product; one issue per cycle accepted.
REQ-017 Accepted in cycle t with no stall, finish SHALL be 1 in cycle t+LAT with the correct res and tag_out.
REQ-018 Product SHALL be formed on XLEN+1-bit extended operands (sign- or zero-extended per op); MUL returns bits [XLEN-1:0], high modes return bits [2*XLEN-1:XLEN].
REQ-019 Output stage full and grant=0 SHALL freeze the whole pipeline (stall); ready=0, finish, res and tag_out held stable.
REQ-020 ready SHALL equal (output stage empty OR grant), combinationally, independent of EN.
REQ-021 Bubbles SHALL advance: in a stall, earlier stages SHALL NOT advance either (no bubble collapsing, keeps ordering and timing simple).
REQ-022 grant while finish=0 SHALL be ignored.
REQ-023 Results SHALL leave in issue order; each accepted operation SHALL produce exactly one finish cycle that coincides with grant, or exactly one pulse if grant is held high.
REQ-024 flush SHALL clear every valid bit at the next edge, including the output stage; finish=0 in the following cycle.
REQ-025 EN in a flush cycle SHALL be ignored; ready is unaffected by flush.
REQ-026 Operand values in invalid stages are don't-care; res SHALL be 0 whenever finish=0.

Reset
REQ-027 rst_n=0 SHALL immediately clear all valid bits; finish=0, res=0, tag_out=0, ready=1.
REQ-028 Reset mid-operation SHALL drop all in-flight work; no finish for any operation issued before reset.
REQ-029 First issue accepted on the first clock edge after rst_n rises.

Structure
REQ-030 Op encodings (OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU) SHALL live in the shared core package.
REQ-031 One sub-module mul_pipe_reg SHALL implement a single enable-gated stage register (valid, op, tag, data), instantiated LAT times by generate.
REQ-032 Product SHALL be computed in stage 1 and carried unchanged through the remaining stages (retiming is left to synthesis).

Verification
REQ-033 Issue MUL A=7, B=6, tag=3, grant=1 held -> finish in cycle t+7, res=42, tag_out=3.
REQ-034 MULH A=0xFFFFFFFF, B=0xFFFFFFFF -> res=0x00000000; MULHU same operands -> res=0xFFFFFFFE; MULHSU A=0xFFFFFFFF, B=2 -> res=0xFFFFFFFF.
REQ-035 Issue tags 1..7 back-to-back with grant=1 -> seven consecutive finish cycles, tags 1..7 in order.
REQ-036 Hold grant=0 after the first finish -> ready=0, res/tag_out stable 5 cycles; raise grant -> remaining results drain in order, none lost or duplicated.
REQ-037 Issue 3 ops, assert flush in cycle t+2 -> no finish for any of them; issue in the same cycle as flush is dropped.
REQ-038 Pulse rst_n low for half a cycle mid-pipeline -> finish, res, tag_out go 0 without a clock edge; ready=1.
